// File: rtl/serial_adder_if.sv
// Handshake and data bundle between a serial_adder and its requester.
// The sub line exists only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             cout;

`ifdef SERIAL_ADDER_SUB_EN
    modport master (output start, a, b, cin, sub, input busy, done, s, cout);
    modport slave  (input start, a, b, cin, sub, output busy, done, s, cout);
`else
    modport master (output start, a, b, cin, input busy, done, s, cout);
    modport slave  (input start, a, b, cin, output busy, done, s, cout);
`endif
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell and a carry flop, LSB first, WIDTH clocks per operation.
// Define SERIAL_ADDER_SUB_EN to add a subtract mode (a + ~b + 1) selected by bus.sub.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input logic          clk,
    input logic          rst,
    serial_adder_if.slave bus
);
    localparam int unsigned     CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastIdx = CntW'(WIDTH - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;

    logic             accept;
    logic             last;
    logic [WIDTH-1:0] b_load;
    logic             c_load;
    logic             h_sum, h_carry, sum_bit, maj;
    logic [WIDTH:0]   res_shift;

`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction is a + ~b + 1: invert b on load and force the initial carry.
    assign b_load = bus.sub ? ~bus.b : bus.b;
    assign c_load = bus.sub | bus.cin;
`else
    assign b_load = bus.b;
    assign c_load = bus.cin;
`endif

    // Requests are only honoured outside RUN, so operands never change mid-operation.
    assign accept = (state_q != StRun) && bus.start;
    assign last   = (cnt_q == LastIdx);

    // Full adder built from two half adders.
    assign h_sum     = a_q[0] ^ b_q[0];
    assign h_carry   = a_q[0] & b_q[0];
    assign sum_bit   = h_sum ^ carry_q;
    assign maj       = h_carry | (h_sum & carry_q);
    assign res_shift = {sum_bit, res_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        s_d     = s_q;
        carry_d = carry_q;
        cout_d  = cout_q;

        if (accept) begin
            state_d = StRun;
            a_d     = bus.a;
            b_d     = b_load;
            carry_d = c_load;
            cnt_d   = '0;
        end else if (state_q == StRun) begin
            carry_d = maj;
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            res_d   = res_shift[WIDTH:1];
            if (last) begin
                state_d = StDone;
                s_d     = res_shift[WIDTH:1];
                cout_d  = maj;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end else begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end

    assign bus.busy = (state_q == StRun);
    assign bus.done = (state_q == StDone);
    assign bus.s    = s_q;
    assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: vector table plus corner sequences, scoreboard on done.
module tb_serial_adder;
    localparam int unsigned W = 8;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] s;
        logic         cout;
    } vec_t;

    typedef struct packed {
        logic [W-1:0] s;
        logic         cout;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];
    vec_t vecs[$];

    serial_adder_if #(.WIDTH(W)) bus ();
    serial_adder_if #(.WIDTH(1)) bus1 ();

    serial_adder #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input logic sub, input logic [W-1:0] s, input logic cout);
        exp_t e;
        bus.a     = a;
        bus.b     = b;
        bus.cin   = cin;
`ifdef SERIAL_ADDER_SUB_EN
        bus.sub   = sub;
`endif
        bus.start = 1'b1;
        e.s       = s;
        e.cout    = cout;
        sb.push_back(e);
    endtask

    task automatic check_result(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: done with empty scoreboard", name);
        end else begin
            e = sb.pop_front();
            check({name, " s"}, 64'(bus.s), 64'(e.s));
            check({name, " cout"}, 64'(bus.cout), 64'(e.cout));
        end
    endtask

    // Called right after the accepting edge; a start pulse with FF/FF operands
    // is injected at edge inject_at (0 = none) to probe the busy lockout.
    task automatic wait_done(input string name, input int inject_at);
        int edges = 1;
        int bc    = 0;
        while (!bus.done && edges < 4 * W + 8) begin
            if (bus.busy) bc++;
            if (edges == inject_at) begin
                bus.start = 1'b1;
                bus.a     = '1;
                bus.b     = '1;
            end else begin
                bus.start = 1'b0;
            end
            tick();
            edges++;
        end
        bus.start = 1'b0;
        check({name, " latency"}, 64'(edges), 64'(W + 1));
        check({name, " busy cycles"}, 64'(bc), 64'(W));
        check({name, " busy at done"}, 64'(bus.busy), 64'(0));
        check_result(name);
    endtask

    initial begin
        logic [W:0] sum;
        logic [W-1:0] ra, rb;
        logic rc;
        int seen;

        vecs.push_back('{a: 8'hFF, b: 8'h01, cin: 1'b0, sub: 1'b0, s: 8'h00, cout: 1'b1});
        vecs.push_back('{a: 8'h5A, b: 8'hA5, cin: 1'b1, sub: 1'b0, s: 8'h00, cout: 1'b1});
        vecs.push_back('{a: 8'h03, b: 8'h04, cin: 1'b0, sub: 1'b0, s: 8'h07, cout: 1'b0});
        vecs.push_back('{a: 8'h80, b: 8'h80, cin: 1'b0, sub: 1'b0, s: 8'h00, cout: 1'b1});
        vecs.push_back('{a: 8'h7F, b: 8'h01, cin: 1'b1, sub: 1'b0, s: 8'h81, cout: 1'b0});
        vecs.push_back('{a: 8'h00, b: 8'h00, cin: 1'b0, sub: 1'b0, s: 8'h00, cout: 1'b0});
        vecs.push_back('{a: 8'hFF, b: 8'hFF, cin: 1'b1, sub: 1'b0, s: 8'hFF, cout: 1'b1});
        vecs.push_back('{a: 8'hAA, b: 8'h55, cin: 1'b0, sub: 1'b0, s: 8'hFF, cout: 1'b0});
`ifdef SERIAL_ADDER_SUB_EN
        vecs.push_back('{a: 8'h10, b: 8'h01, cin: 1'b0, sub: 1'b1, s: 8'h0F, cout: 1'b1});
        vecs.push_back('{a: 8'h00, b: 8'h01, cin: 1'b1, sub: 1'b1, s: 8'hFF, cout: 1'b0});
        vecs.push_back('{a: 8'h23, b: 8'h23, cin: 1'b0, sub: 1'b1, s: 8'h00, cout: 1'b1});
        bus.sub  = 1'b0;
        bus1.sub = 1'b0;
`endif

        // Reset with start asserted: reset must win.
        rst        = 1'b1;
        bus.start  = 1'b1;
        bus.a      = 8'hFF;
        bus.b      = 8'hFF;
        bus.cin    = 1'b1;
        bus1.start = 1'b0;
        bus1.a     = '0;
        bus1.b     = '0;
        bus1.cin   = 1'b0;
        tick();
        tick();
        check("reset busy", 64'(bus.busy), 64'(0));
        check("reset done", 64'(bus.done), 64'(0));
        check("reset s", 64'(bus.s), 64'(0));
        check("reset cout", 64'(bus.cout), 64'(0));
        rst       = 1'b0;
        bus.start = 1'b0;
        tick();
        check("idle without start", 64'(bus.busy), 64'(0));

        foreach (vecs[i]) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, vecs[i].s, vecs[i].cout);
            tick();
            wait_done($sformatf("vec%0d", i), 0);
            tick();
            check($sformatf("vec%0d done pulse width", i), 64'(bus.done), 64'(0));
            check($sformatf("vec%0d s held", i), 64'(bus.s), 64'(vecs[i].s));
        end
`ifdef SERIAL_ADDER_SUB_EN
        bus.sub = 1'b0;
`endif

        // Back-to-back: start held during the DONE cycle.
        issue(8'h5A, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b1);
        tick();
        wait_done("b2b first", 0);
        issue(8'h03, 8'h04, 1'b0, 1'b0, 8'h07, 1'b0);
        tick();
        check("b2b accepted from done", 64'(bus.busy), 64'(1));
        wait_done("b2b second", 0);
        tick();

        // Start while busy is ignored and operand changes do not leak in.
        issue(8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0);
        tick();
        wait_done("ignore start", 3);
        tick();

        // Reset mid-RUN abandons the operation.
        issue(8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0);
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        void'(sb.pop_back());
        check("mid-run rst busy", 64'(bus.busy), 64'(0));
        check("mid-run rst done", 64'(bus.done), 64'(0));
        check("mid-run rst s", 64'(bus.s), 64'(0));
        check("mid-run rst cout", 64'(bus.cout), 64'(0));
        seen = 0;
        for (int k = 0; k < 2 * W; k++) begin
            if (bus.done || bus.busy) seen++;
            tick();
        end
        check("no activity after rst", 64'(seen), 64'(0));
        issue(8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0);
        tick();
        wait_done("after rst", 0);
        tick();

        // Randomised operations against an arithmetic model.
        for (int k = 0; k < 8; k++) begin
            ra  = W'($urandom);
            rb  = W'($urandom);
            rc  = 1'($urandom);
            sum = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
            issue(ra, rb, rc, 1'b0, sum[W-1:0], sum[W]);
            tick();
            wait_done($sformatf("rand%0d", k), 0);
            tick();
        end
        check("scoreboard drained", 64'(sb.size()), 64'(0));

        // WIDTH=1 instance: one RUN cycle, done on the second edge.
        bus1.a     = 1'b1;
        bus1.b     = 1'b1;
        bus1.cin   = 1'b1;
        bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        check("w1 busy", 64'(bus1.busy), 64'(1));
        check("w1 no early done", 64'(bus1.done), 64'(0));
        tick();
        check("w1 done", 64'(bus1.done), 64'(1));
        check("w1 busy low", 64'(bus1.busy), 64'(0));
        check("w1 s", 64'(bus1.s), 64'(1));
        check("w1 cout", 64'(bus1.cout), 64'(1));
        tick();
        check("w1 done pulse width", 64'(bus1.done), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
